// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio path: default widths, midscale and the
// sample-scheduler state encoding.
package pwm_audio_pkg;

    localparam int SAMPLE_W_DEF = 12;
    localparam int PERIOD_DEF   = 4095;
    localparam logic [SAMPLE_W_DEF-1:0] MID = SAMPLE_W_DEF'(1 << (SAMPLE_W_DEF - 1));

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        MUTING   = 3'd2,
        MUTED    = 3'd3,
        UNMUTING = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that clears it in
// one clock. The head entry is always visible on dout.
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 12,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over a same-cycle push, so that entry is lost.
    assign empty   = (level == '0);
    assign do_push = push && (level != LVL_W'(DEPTH)) && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (!do_push && do_pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_sample_sched.sv
// Frame scheduler in front of pwm_audio: buffers producer samples and releases
// one per PWM frame at the frame boundary, with underrun hold and mute ramps.
module pwm_sample_sched
    import pwm_audio_pkg::*;
#(
    parameter  int SAMPLE_W   = SAMPLE_W_DEF,
    parameter  int PERIOD     = PERIOD_DEF,
    parameter  int FIFO_DEPTH = 4,
    parameter  int RAMP_STEP  = 64,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mute,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic                frame_strobe,
    output logic                underrun,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [2:0]          state
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]           LAST    = CNT_W'(PERIOD - 1);
    localparam logic [SAMPLE_W-1:0]        MID_S   = SAMPLE_W'(1 << (SAMPLE_W - 1));
    localparam logic [SAMPLE_W-1:0]        STEP_U  = SAMPLE_W'(RAMP_STEP);
    localparam logic signed [SAMPLE_W:0]   STEP_S  = (SAMPLE_W + 1)'(RAMP_STEP);

    sched_state_t        st;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] target;
    logic [SAMPLE_W-1:0] head;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [SAMPLE_W-1:0] unmute_tgt;
    logic [SAMPLE_W-1:0] mute_step;
    logic [SAMPLE_W-1:0] unmute_step;

    // One step of at most RAMP_STEP toward tgt; lands exactly on tgt when close.
    function automatic logic [SAMPLE_W-1:0] ramp_toward(
        input logic [SAMPLE_W-1:0] cur,
        input logic [SAMPLE_W-1:0] tgt
    );
        logic signed [SAMPLE_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) begin
            return cur + STEP_U;
        end else if (diff < -STEP_S) begin
            return cur - STEP_U;
        end else begin
            return tgt;
        end
    endfunction

    // Handshake: a sample transfers on any clock where s_valid && s_ready.
    // s_ready looks only at the registered level, so a pop in the same cycle
    // never frees room for a push; it also drops in reset and while idle.
    assign s_ready      = !rst && (st != IDLE) && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push         = s_valid && s_ready && en;
    assign frame_strobe = !rst && en && (st != IDLE) && (cnt == LAST);
    assign pop          = frame_strobe && !fifo_empty;

    assign unmute_tgt  = fifo_empty ? target : head;
    assign mute_step   = ramp_toward(sample, MID_S);
    assign unmute_step = ramp_toward(sample, unmute_tgt);
    assign state       = st;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!en),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (head),
        .level (fifo_level),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            st       <= IDLE;
            cnt      <= '0;
            sample   <= MID_S;
            target   <= MID_S;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (st == IDLE) begin
                cnt <= '0;
                st  <= mute ? MUTED : RUN;
            end else begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                if (frame_strobe) begin
                    // Remember the newest stream value as the unmute target.
                    if (!fifo_empty) begin
                        target <= head;
                    end
                    case (st)
                        RUN: begin
                            if (!fifo_empty) begin
                                sample <= head;
                            end else begin
                                underrun <= 1'b1;
                            end
                            if (mute) begin
                                st <= MUTING;
                            end
                        end
                        MUTING: begin
                            sample <= mute_step;
                            if (mute_step == MID_S) begin
                                st <= MUTED;
                            end
                        end
                        MUTED: begin
                            sample <= MID_S;
                            if (!mute) begin
                                st <= UNMUTING;
                            end
                        end
                        UNMUTING: begin
                            if (mute) begin
                                sample <= mute_step;
                                st     <= (mute_step == MID_S) ? MUTED : MUTING;
                            end else begin
                                sample <= unmute_step;
                                if (unmute_step == unmute_tgt) begin
                                    st <= RUN;
                                end
                            end
                        end
                        default: begin
                            st <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Directed bench for pwm_sample_sched: frame-by-frame vector table plus
// hand sequences for FIFO-full, enable/reset aborts and full-length frames.
module tb_pwm_sample_sched;
    import pwm_audio_pkg::*;

    localparam int SW      = 12;
    localparam int P_SHORT = 16;
    localparam int P_LONG  = 4095;
    localparam int LVL_W   = 3;

    typedef struct {
        logic          valid;
        logic [SW-1:0] data;
        logic          mute;
        logic [SW-1:0] exp_sample;
        logic          exp_underrun;
        logic [2:0]    exp_state;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en, mute, s_valid;
    logic [SW-1:0]    s_data;
    logic             s_ready, frame_strobe, underrun;
    logic [SW-1:0]    sample;
    logic [LVL_W-1:0] fifo_level;
    logic [2:0]       state;

    logic             rst_l, en_l, mute_l, s_valid_l;
    logic [SW-1:0]    s_data_l;
    logic             s_ready_l, strobe_l, underrun_l;
    logic [SW-1:0]    sample_l;
    logic [LVL_W-1:0] level_l;
    logic [2:0]       state_l;

    pwm_sample_sched #(.PERIOD(P_SHORT)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mute(mute),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .sample(sample), .frame_strobe(frame_strobe), .underrun(underrun),
        .fifo_level(fifo_level), .state(state)
    );

    pwm_sample_sched #(.PERIOD(P_LONG)) u_long (
        .clk(clk), .rst(rst_l), .en(en_l), .mute(mute_l),
        .s_valid(s_valid_l), .s_ready(s_ready_l), .s_data(s_data_l),
        .sample(sample_l), .frame_strobe(strobe_l), .underrun(underrun_l),
        .fifo_level(level_l), .state(state_l)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [SW-1:0] exp_q[$];
    vec_t vecs[$];

    // scoreboard helpers
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name);
        for (int i = 0; i < 4 * P_SHORT; i++) begin
            step();
            if (frame_strobe) return;
        end
        fail_timeout(name);
    endtask

    task automatic push_one(input logic [SW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 64; i++) begin
            if (s_ready) begin
                step();
                s_valid = 1'b0;
                return;
            end
            step();
        end
        s_valid = 1'b0;
        fail_timeout("push_one");
    endtask

    task automatic add_vec(input logic v, input logic [SW-1:0] d, input logic m,
                           input logic [SW-1:0] es, input logic eu, input sched_state_t est);
        vec_t r;
        r.valid = v; r.data = d; r.mute = m;
        r.exp_sample = es; r.exp_underrun = eu; r.exp_state = est;
        vecs.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] prev_exp;
        int n;
        int t[$];

        rst = 1'b1; en = 1'b0; mute = 1'b0; s_valid = 1'b0; s_data = '0;
        rst_l = 1'b1; en_l = 1'b0; mute_l = 1'b0; s_valid_l = 1'b0; s_data_l = '0;

        // reset state
        repeat (3) step();
        check("rst_sample", sample, 2048);
        check("rst_strobe", frame_strobe, 0);
        check("rst_underrun", underrun, 0);
        check("rst_level", fifo_level, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_state", state, int'(IDLE));
        rst = 1'b0; rst_l = 1'b0;
        step();
        check("idle_s_ready", s_ready, 0);

        // 1: three samples released one per frame, changing at count 0
        en = 1'b1;
        step();
        check("t1_state_run", state, int'(RUN));
        push_one(12'd100); exp_q.push_back(12'd100);
        push_one(12'd200); exp_q.push_back(12'd200);
        push_one(12'd300); exp_q.push_back(12'd300);
        check("t1_level", fifo_level, 3);
        check("t1_frame0_mid", sample, 2048);
        prev_exp = 12'd2048;
        while (exp_q.size() > 0) begin
            wait_strobe("t1_strobe");
            check("t1_hold_at_strobe", sample, prev_exp);
            step();
            prev_exp = exp_q.pop_front();
            check("t1_new_at_count0", sample, prev_exp);
        end

        // 2: full FIFO with s_valid held
        s_valid = 1'b1; s_data = 12'd500;
        for (int i = 0; i < 8 && fifo_level != 3'd4; i++) step();
        check("t2_level_full", fifo_level, 4);
        check("t2_ready_full", s_ready, 0);
        wait_strobe("t2_strobe");
        check("t2_level_at_strobe", fifo_level, 4);
        check("t2_ready_at_strobe", s_ready, 0);
        step();
        check("t2_level_after_pop", fifo_level, 3);
        check("t2_ready_after_pop", s_ready, 1);
        check("t2_sample_500", sample, 500);
        step();
        check("t2_level_refill", fifo_level, 4);

        // 3 + 4: underrun hold, resume, mute ramp down and unmute ramp up
        for (int i = 0; i < 4; i++) add_vec(1'b0, 12'd0, 1'b0, 12'd500, 1'b0, RUN);
        add_vec(1'b0, 12'd0, 1'b0, 12'd500, 1'b1, RUN);
        add_vec(1'b1, 12'd4000, 1'b0, 12'd4000, 1'b0, RUN);
        add_vec(1'b1, 12'd4000, 1'b1, 12'd4000, 1'b0, MUTING);
        for (int k = 1; k <= 30; k++)
            add_vec(1'b1, 12'd2348, 1'b1, 12'(4000 - 64 * k), 1'b0, MUTING);
        add_vec(1'b1, 12'd2348, 1'b1, 12'd2048, 1'b0, MUTED);
        add_vec(1'b1, 12'd2348, 1'b1, 12'd2048, 1'b0, MUTED);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2048, 1'b0, UNMUTING);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2112, 1'b0, UNMUTING);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2176, 1'b0, UNMUTING);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2240, 1'b0, UNMUTING);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2304, 1'b0, UNMUTING);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2348, 1'b0, RUN);
        add_vec(1'b1, 12'd2348, 1'b0, 12'd2348, 1'b0, RUN);

        prev_exp = 12'd500;
        foreach (vecs[i]) begin
            s_valid = vecs[i].valid;
            s_data  = vecs[i].data;
            mute    = vecs[i].mute;
            wait_strobe($sformatf("row%0d_strobe", i));
            check($sformatf("row%0d_hold", i), sample, prev_exp);
            step();
            check($sformatf("row%0d_sample", i), sample, vecs[i].exp_sample);
            check($sformatf("row%0d_underrun", i), underrun, vecs[i].exp_underrun);
            check($sformatf("row%0d_state", i), state, vecs[i].exp_state);
            prev_exp = vecs[i].exp_sample;
        end

        // 5a: en=0 mid-frame with three entries queued; concurrent push dropped
        s_valid = 1'b0;
        repeat (3) step();
        check("t5_level_before", fifo_level, 3);
        en = 1'b0; s_valid = 1'b1; s_data = 12'd777;
        step();
        check("t5_sample_mid", sample, 2048);
        check("t5_level_flushed", fifo_level, 0);
        check("t5_state_idle", state, int'(IDLE));
        check("t5_ready_idle", s_ready, 0);
        s_valid = 1'b0;
        en = 1'b1;
        step();
        n = 1;
        check("t5_state_run", state, int'(RUN));
        while (!frame_strobe && n < 4 * P_SHORT) begin
            step();
            n++;
        end
        check("t5_first_strobe_delay", n, P_SHORT);
        step();
        check("t5_underrun_empty", underrun, 1);
        check("t5_sample_hold_mid", sample, 2048);

        // 5b: rst mid-ramp
        push_one(12'd4000);
        wait_strobe("t5b_strobe1");
        step();
        check("t5b_sample_4000", sample, 4000);
        mute = 1'b1;
        wait_strobe("t5b_strobe2");
        step();
        check("t5b_state_muting", state, int'(MUTING));
        check("t5b_sample_hold", sample, 4000);
        wait_strobe("t5b_strobe3");
        step();
        check("t5b_sample_3936", sample, 3936);
        push_one(12'd1234);
        check("t5b_level_1", fifo_level, 1);
        rst = 1'b1;
        step();
        check("t5b_rst_sample", sample, 2048);
        check("t5b_rst_state", state, int'(IDLE));
        check("t5b_rst_level", fifo_level, 0);
        check("t5b_rst_ready", s_ready, 0);
        check("t5b_rst_strobe", frame_strobe, 0);
        check("t5b_rst_underrun", underrun, 0);
        rst = 1'b0; mute = 1'b0; en = 1'b0;

        // 6: full-length frames on the default-period instance
        en_l = 1'b1;
        for (int c = 0; c < 20000 && t.size() < 4; c++) begin
            step();
            if (strobe_l) t.push_back(c);
        end
        if (t.size() < 4) begin
            fail_timeout("t6_strobes");
        end else begin
            check("t6_first_strobe", t[0], P_LONG - 1);
            for (int i = 1; i < 4; i++)
                check($sformatf("t6_period%0d", i), t[i] - t[i-1], P_LONG);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
